// File: rtl/router_port_scheduler_if.sv
// router_port_scheduler_if: request/size/ack bundle between router and scheduler.
// Ports: master = scheduler side, slave = router/downstream side.
interface router_port_scheduler_if #(
  parameter int NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0]   req;
  logic [3*NUM_PORTS-1:0] req_size;
  logic [2:0]             capacity_in;
  logic                   ack_valid;
  logic                   ack_ok;
  logic [NUM_PORTS-1:0]   grant;
  logic [2:0]             sel;
  logic [NUM_PORTS-1:0]   pop;
  logic                   load_en;
  logic                   write_out;
  logic [2:0]             flit_idx;
  logic                   done;
  logic                   drop;
  logic                   busy;

  modport master (
    input  req, req_size, capacity_in,
    input  ack_valid, ack_ok,
    output grant, sel, pop, load_en,
    output write_out, flit_idx,
    output done, drop, busy
  );

  modport slave (
    output req, req_size, capacity_in,
    output ack_valid, ack_ok,
    input  grant, sel, pop, load_en,
    input  write_out, flit_idx,
    input  done, drop, busy
  );
endinterface

// File: rtl/router_port_scheduler.sv
// router_port_scheduler: round-robin output-port scheduler with ack/replay.
// Ports: clock, reset_n (sync, active-low), bus (router_port_scheduler_if.master).
// Optional macro SCHED_TIMEOUT_EN: implicit nack after ACK_TIMEOUT WAIT_ACK cycles.
module router_port_scheduler #(
  parameter int NUM_PORTS   = 5,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset_n,
  router_port_scheduler_if.master bus
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT
  } state_t;

  state_t               r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [2:0]           r_sel;
  logic [2:0]           r_size;
  logic [2:0]           r_flit;
  logic [2:0]           r_rr;
  logic [RW-1:0]        r_retry;
  logic                 r_done;
  logic                 r_drop;

  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_found;
  logic [2:0]           w_win;
  logic [2:0]           w_win_size;
  logic [3:0]           w_sum;
  logic                 w_last;
  logic                 w_ack;
  logic                 w_nack;

  // A size field of zero still carries one flit.
  function automatic logic [2:0] eff_size(
    input logic [2:0] s
  );
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = bus.req[i] &&
        (eff_size(bus.req_size[3*i +: 3])
         <= bus.capacity_in);
    end
  end

  // Rotating search: first eligible buffer at or after r_rr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_rr} + 4'(k);
      if (w_sum >= 4'(NUM_PORTS))
        w_sum = w_sum - 4'(NUM_PORTS);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!w_found && w_sum == 4'(i) &&
            w_elig[i]) begin
          w_found = 1'b1;
          w_win   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_win_size = 3'd1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_win == 3'(i))
        w_win_size = eff_size(bus.req_size[3*i +: 3]);
    end
  end

  assign w_last = (r_flit == r_size - 3'd1);
  assign w_ack  = bus.ack_valid && bus.ack_ok;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] r_to;
  logic          w_expire;

  // Held at zero outside WAIT_ACK, so every entry starts a fresh count.
  always_ff @(posedge clock) begin
    if (!reset_n || r_state != S_WAIT)
      r_to <= '0;
    else
      r_to <= r_to + 1'b1;
  end

  // A real ack/nack in the expiry cycle takes precedence.
  assign w_expire = (r_to == TW'(ACK_TIMEOUT - 1));
  assign w_nack   = bus.ack_valid ? !bus.ack_ok
                                  : w_expire;
`else
  assign w_nack = bus.ack_valid && !bus.ack_ok;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_size  <= '0;
      r_flit  <= '0;
      r_rr    <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_drop <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_LOAD;
            r_grant <= NUM_PORTS'(1) << w_win;
            r_sel   <= w_win;
            r_size  <= w_win_size;
            r_flit  <= '0;
            r_rr    <= (w_win == 3'(NUM_PORTS - 1))
                       ? 3'd0 : w_win + 3'd1;
          end
        end
        S_LOAD: begin
          if (w_last) begin
            r_flit  <= '0;
            r_state <= S_SEND;
          end else begin
            r_flit <= r_flit + 3'd1;
          end
        end
        S_SEND: begin
          if (w_last)
            r_state <= S_WAIT;
          else
            r_flit <= r_flit + 3'd1;
        end
        S_WAIT: begin
          if (w_ack) begin
            r_done  <= 1'b1;
            r_retry <= '0;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (w_nack) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_flit  <= '0;
              r_state <= S_SEND;
            end else begin
              r_drop  <= 1'b1;
              r_retry <= '0;
              r_grant <= '0;
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.pop       = (r_state == S_LOAD) ? r_grant : '0;
  assign bus.load_en   = (r_state == S_LOAD);
  assign bus.write_out = (r_state == S_SEND);
  assign bus.flit_idx  = r_flit;
  assign bus.done      = r_done;
  assign bus.drop      = r_drop;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_router_port_scheduler.sv
// tb_router_port_scheduler: directed + randomized checks of router_port_scheduler.
// Reference: round-robin pick and per-packet cycle timeline computed in the bench.
module tb_router_port_scheduler;
  localparam int MAX_RETRY = 3;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  router_port_scheduler_if #(.NUM_PORTS(5)) bus();

  router_port_scheduler #(
    .NUM_PORTS  (5),
    .MAX_RETRY  (MAX_RETRY),
    .ACK_TIMEOUT(15)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errs   = 0;
  int checks = 0;
  int m_rr   = 0;
  int g_sel  = 0;
  int order[6] = '{0, 1, 2, 3, 4, 0};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic int eff(input logic [2:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [2:0] size_of(
    input logic [14:0] sz, input int b);
    logic [14:0] t;
    t = sz >> (3 * b);
    return t[2:0];
  endfunction

  // Spec rule: first buffer from m_rr with req and size <= capacity.
  function automatic int pick(input logic [4:0] rq,
                              input logic [14:0] sz,
                              input logic [2:0] cap);
    for (int k = 0; k < 5; k++) begin
      int b;
      b = (m_rr + k) % 5;
      if (rq[b] && eff(size_of(sz, b)) <= int'(cap))
        return b;
    end
    return -1;
  endfunction

  task automatic zero_chk(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_pop"},   bus.pop, 0);
    chk({tag, "_sel"},   bus.sel, 0);
    chk({tag, "_flit"},  bus.flit_idx, 0);
    chk({tag, "_load"},  bus.load_en, 0);
    chk({tag, "_wr"},    bus.write_out, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_drop"},  bus.drop, 0);
    chk({tag, "_busy"},  bus.busy, 0);
  endtask

  task automatic noise;
    bus.ack_valid = 1'($urandom_range(0, 1));
    bus.ack_ok    = 1'($urandom_range(0, 1));
  endtask

  task automatic arb(input logic [4:0] rq,
                     input logic [14:0] sz,
                     input logic [2:0] cap,
                     output int win);
    logic [4:0] oh;
    win = pick(rq, sz, cap);
    bus.req = rq;
    bus.req_size = sz;
    bus.capacity_in = cap;
    step;
    g_sel = int'(bus.sel);
    if (win < 0) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_grant", bus.grant, 0);
    end else begin
      oh = 5'(1) << win;
      chk("grant", bus.grant, oh);
      chk("sel", bus.sel, win);
      chk("busy", bus.busy, 1);
      m_rr = (win + 1) % 5;
    end
  endtask

  task automatic load_phase(input int win, input int size);
    logic [4:0] oh;
    oh = 5'(1) << win;
    for (int f = 0; f < size; f++) begin
      chk("load_pop", bus.pop, oh);
      chk("load_en", bus.load_en, 1);
      chk("load_flit", bus.flit_idx, f);
      chk("load_wr", bus.write_out, 0);
      chk("load_done", bus.done | bus.drop, 0);
      noise;
      step;
    end
    bus.ack_valid = 1'b0;
  endtask

  task automatic send_phase(input int win, input int size);
    logic [4:0] oh;
    oh = 5'(1) << win;
    for (int f = 0; f < size; f++) begin
      chk("send_wr", bus.write_out, 1);
      chk("send_flit", bus.flit_idx, f);
      chk("send_load", bus.load_en | (|bus.pop), 0);
      chk("send_grant", bus.grant, oh);
      chk("send_done", bus.done | bus.drop, 0);
      noise;
      step;
    end
    bus.ack_valid = 1'b0;
  endtask

  // One full packet: nacks replies of nack then an ack (or a drop).
  task automatic packet(input logic [4:0] rq,
                        input logic [14:0] sz,
                        input logic [2:0] cap,
                        input int nacks);
    int win;
    int size;
    int att;
    arb(rq, sz, cap, win);
    if (win < 0) return;
    size = eff(size_of(sz, win));
    bus.req = 5'($urandom);
    bus.capacity_in = 3'($urandom);
    load_phase(win, size);
    att = 0;
    while (1) begin
      send_phase(win, size);
      repeat ($urandom_range(0, 3)) begin
        chk("wait_busy", bus.busy, 1);
        chk("wait_wr", bus.write_out, 0);
        chk("wait_done", bus.done | bus.drop, 0);
        bus.ack_valid = 1'b0;
        bus.ack_ok = 1'($urandom_range(0, 1));
        step;
      end
      bus.ack_valid = 1'b1;
      bus.ack_ok = (att >= nacks);
      step;
      bus.ack_valid = 1'b0;
      if (att >= nacks) begin
        chk("ack_done", bus.done, 1);
        chk("ack_drop", bus.drop, 0);
        chk("ack_busy", bus.busy, 0);
        chk("ack_grant", bus.grant, 0);
        break;
      end
      if (att == MAX_RETRY) begin
        chk("drop_pulse", bus.drop, 1);
        chk("drop_done", bus.done, 0);
        chk("drop_busy", bus.busy, 0);
        chk("drop_grant", bus.grant, 0);
        break;
      end
      chk("nack_done", bus.done | bus.drop, 0);
      att++;
    end
  endtask

  initial begin
    int win;
    int r;
    logic [14:0] sz;
    bus.req = '0;
    bus.req_size = '0;
    bus.capacity_in = '0;
    bus.ack_valid = 1'b0;
    bus.ack_ok = 1'b0;
    reset_n = 1'b0;
    step;
    step;
    zero_chk("reset");
    reset_n = 1'b1;
    m_rr = 0;

    for (int i = 0; i < 6; i++) begin
      packet(5'b11111, {5{3'd1}}, 3'd7, 0);
      chk("fair_order", g_sel, order[i]);
    end

    sz = 15'd3 << 6;
    packet(5'b00100, sz, 3'd7, 0);
    chk("single_sel", g_sel, 2);
    packet(5'b11111, {5{3'd1}}, 3'd7, 0);
    chk("rr_after_single", g_sel, 3);

    sz = {9'd0, 3'd2, 3'd5};
    packet(5'b00011, sz, 3'd3, 0);
    chk("cap_gate", g_sel, 1);
    packet(5'b00001, sz, 3'd5, 0);
    chk("cap_raise", g_sel, 0);

    sz = 15'd2 << 6;
    packet(5'b00100, sz, 3'd7, MAX_RETRY + 1);
    packet(5'b00100, sz, 3'd7, 1);

`ifdef SCHED_TIMEOUT_EN
    arb(5'b00001, 15'd1, 3'd7, win);
    load_phase(win, 1);
    send_phase(win, 1);
    for (int w = 0; w < 15; w++) begin
      chk("to_wait_wr", bus.write_out, 0);
      chk("to_wait_busy", bus.busy, 1);
      step;
    end
    send_phase(win, 1);
    for (int w = 0; w < 14; w++) begin
      chk("to_wait2_wr", bus.write_out, 0);
      step;
    end
    bus.ack_valid = 1'b1;
    bus.ack_ok = 1'b1;
    step;
    bus.ack_valid = 1'b0;
    chk("to_ack_done", bus.done, 1);
    chk("to_ack_wr", bus.write_out, 0);
    chk("to_ack_busy", bus.busy, 0);
`endif

    sz = 15'd3 << 6;
    arb(5'b00100, sz, 3'd7, win);
    load_phase(win, 3);
    chk("rst_send0", bus.write_out, 1);
    step;
    chk("rst_send1", bus.flit_idx, 1);
    reset_n = 1'b0;
    step;
    zero_chk("rst_mid");
    reset_n = 1'b1;
    m_rr = 0;
    packet(5'b11111, {5{3'd1}}, 3'd7, 0);
    chk("rst_rr", g_sel, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      packet(5'($urandom), 15'($urandom),
             3'($urandom),
             (r < 6) ? 0 : (r < 8) ? 1 :
             (r < 9) ? 2 : MAX_RETRY + 1);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
